// File: rtl/operand_issue.sv
// ----------------------------------------------------------------------------
// operand_issue
// Decode/operand stage in front of the 8-bit ALU. Accepts 16-bit instructions,
// reads an 8x8 register file (R0 reads as zero), registers operands and op into
// a single issue slot that drives the ALU, and commits the ALU result back to
// the register file at the end of the issue cycle. Compare ops latch the ALU
// condition bit into cond_flag instead of writing a register.
//
// Configuration macro: OPERAND_BYPASS_EN
//   defined   : operand reads forward alu_out from the slot, never stall
//   undefined : RAW on the slot's destination inserts exactly one bubble
//
// Ports
//   clk        in   clock, all state on posedge
//   sync_rst   in   synchronous active-high reset, overrides clk_en
//   clk_en     in   global advance; low holds all state
//   in_valid   in   instr is valid
//   in_ready   out  stage accepts instr this cycle (combinational)
//   instr      in   [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [7:0] imm
//   alu_a      out  issue-slot operand A
//   alu_b      out  issue-slot operand B
//   alu_op     out  issue-slot ALU op
//   alu_en     out  ALU clock enable = clk_en & slot valid (combinational)
//   alu_out    in   ALU result for the slot (combinational)
//   alu_cond   in   ALU condition bit
//   cond_flag  out  last compare result
//   retire     out  slot commits at this edge = clk_en & slot valid
// ----------------------------------------------------------------------------
module operand_issue #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned REG_ADDR_W = 3,
   parameter int unsigned INSTR_W    = 16
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  clk_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSTR_W-1:0]    instr,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [3:0]            alu_op,
   output logic                  alu_en,
   input  logic [DATA_W-1:0]     alu_out,
   input  logic                  alu_cond,
   output logic                  cond_flag,
   output logic                  retire
);

   localparam int unsigned OP_W     = 4;
   localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
   localparam int unsigned OP_MSB   = INSTR_W - 1;
   localparam int unsigned RD_MSB   = OP_MSB - OP_W;
   localparam int unsigned RA_MSB   = RD_MSB - REG_ADDR_W;
   localparam int unsigned RB_MSB   = RA_MSB - REG_ADDR_W;

   localparam logic [OP_W-1:0] OP_LDI      = 4'b1111;
   localparam logic [OP_W-1:0] OP_EQ       = 4'b1011;
   localparam logic [OP_W-1:0] OP_GT       = 4'b1100;
   localparam logic [OP_W-1:0] LDI_ALU_OP  = 4'b0000;

   // State
   logic [DATA_W-1:0]     regs_q [NUM_REGS];
   logic [DATA_W-1:0]     regs_d [NUM_REGS];
   logic                  iss_valid_q, iss_valid_d;
   logic                  iss_wb_q, iss_wb_d;
   logic                  iss_cmp_q, iss_cmp_d;
   logic [REG_ADDR_W-1:0] iss_rd_q, iss_rd_d;
   logic [DATA_W-1:0]     iss_a_q, iss_a_d;
   logic [DATA_W-1:0]     iss_b_q, iss_b_d;
   logic [OP_W-1:0]       iss_op_q, iss_op_d;
   logic                  cond_flag_q, cond_flag_d;

   // Decode
   logic [OP_W-1:0]       dec_op;
   logic [REG_ADDR_W-1:0] dec_rd, dec_ra, dec_rb;
   logic [DATA_W-1:0]     dec_imm;
   logic                  is_ldi, is_cmp;
   logic                  slot_wr;
   logic [DATA_W-1:0]     rd_a, rd_b;
   logic                  accept, commit;

   assign dec_op  = instr[OP_MSB -: OP_W];
   assign dec_rd  = instr[RD_MSB -: REG_ADDR_W];
   assign dec_ra  = instr[RA_MSB -: REG_ADDR_W];
   assign dec_rb  = instr[RB_MSB -: REG_ADDR_W];
   assign dec_imm = instr[DATA_W-1:0];

   // Operand read, readiness and the pending write of the slot
   always_comb begin
      is_ldi  = (dec_op == OP_LDI);
      is_cmp  = (dec_op == OP_EQ) || (dec_op == OP_GT);
      // slot will write a real register at the next committing edge
      slot_wr = iss_valid_q & iss_wb_q & (iss_rd_q != '0);
`ifdef OPERAND_BYPASS_EN
      if (dec_ra == '0)                         rd_a = '0;
      else if (slot_wr && (dec_ra == iss_rd_q)) rd_a = alu_out;
      else                                      rd_a = regs_q[dec_ra];
      if (dec_rb == '0)                         rd_b = '0;
      else if (slot_wr && (dec_rb == iss_rd_q)) rd_b = alu_out;
      else                                      rd_b = regs_q[dec_rb];
      in_ready = clk_en;
`else
      rd_a     = (dec_ra == '0) ? DATA_W'(0) : regs_q[dec_ra];
      rd_b     = (dec_rb == '0) ? DATA_W'(0) : regs_q[dec_rb];
      // ra is compared even for LDI (conservative); rb only when used
      in_ready = clk_en & ~(slot_wr & ((dec_ra == iss_rd_q) |
                                       (~is_ldi & (dec_rb == iss_rd_q))));
`endif
      accept = in_valid & in_ready;
      commit = clk_en & iss_valid_q;
   end

   // Next state: commit the slot, then load or bubble it
   always_comb begin
      regs_d      = regs_q;
      iss_valid_d = iss_valid_q;
      iss_wb_d    = iss_wb_q;
      iss_cmp_d   = iss_cmp_q;
      iss_rd_d    = iss_rd_q;
      iss_a_d     = iss_a_q;
      iss_b_d     = iss_b_q;
      iss_op_d    = iss_op_q;
      cond_flag_d = cond_flag_q;

      if (commit) begin
         if (iss_wb_q && (iss_rd_q != '0)) regs_d[iss_rd_q] = alu_out;
         if (iss_cmp_q)                    cond_flag_d      = alu_cond;
      end

      if (clk_en) begin
         iss_valid_d = accept;
         if (accept) begin
            iss_rd_d  = dec_rd;
            iss_wb_d  = ~is_cmp;
            iss_cmp_d = is_cmp;
            if (is_ldi) begin
               iss_op_d = LDI_ALU_OP;
               iss_a_d  = '0;
               iss_b_d  = dec_imm;
            end else begin
               iss_op_d = dec_op;
               iss_a_d  = rd_a;
               iss_b_d  = rd_b;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         regs_q      <= '{default: '0};
         iss_valid_q <= 1'b0;
         iss_wb_q    <= 1'b0;
         iss_cmp_q   <= 1'b0;
         iss_rd_q    <= '0;
         iss_a_q     <= '0;
         iss_b_q     <= '0;
         iss_op_q    <= '0;
         cond_flag_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         iss_valid_q <= iss_valid_d;
         iss_wb_q    <= iss_wb_d;
         iss_cmp_q   <= iss_cmp_d;
         iss_rd_q    <= iss_rd_d;
         iss_a_q     <= iss_a_d;
         iss_b_q     <= iss_b_d;
         iss_op_q    <= iss_op_d;
         cond_flag_q <= cond_flag_d;
      end
   end

   assign alu_a     = iss_a_q;
   assign alu_b     = iss_b_q;
   assign alu_op    = iss_op_q;
   assign cond_flag = cond_flag_q;
   assign alu_en    = clk_en & iss_valid_q;
   assign retire    = clk_en & iss_valid_q;

endmodule
